// File: rtl/sha_sweep_ctrl_pkg.sv
// Shared state encoding and widths for the nonce-sweep controller that sequences the SHA-256 compression datapath.
package sha_sweep_ctrl_pkg;

  localparam int ROUNDS_DEF = 64;
  localparam int NONCE_W    = 32;
  localparam int RIDX_W     = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FINAL = 3'd3,
    ST_VALID = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/sha_nonce_counter.sv
// Nonce register plus a down-counter of nonces left in the sweep.
// The last-nonce decision uses the down-counter only, so nonce wrap at 2^32 is harmless.
module sha_nonce_counter
  import sha_sweep_ctrl_pkg::*;
#(
  parameter logic [NONCE_W-1:0] NONCE_BASE  = '0,
  parameter int                 NONCE_COUNT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               advance,
  output logic [NONCE_W-1:0] nonce,
  output logic               last_nonce
);

  localparam logic [31:0] LEFT_INIT = 32'(NONCE_COUNT - 1);

  logic [31:0] left;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nonce <= NONCE_BASE;
      left  <= LEFT_INIT;
    end else if (load) begin
      nonce <= NONCE_BASE;
      left  <= LEFT_INIT;
    end else if (advance) begin
      nonce <= nonce + 32'd1;
      left  <= left - 32'd1;
    end
  end

  assign last_nonce = (left == 32'd0);

endmodule

// File: rtl/sha_sweep_ctrl.sv
// Responder-side sweep controller: accepts start, walks NONCE_COUNT nonces through
// init / ROUNDS rounds / final add / digest strobe, counts hits and reports found_all.
module sha_sweep_ctrl
  import sha_sweep_ctrl_pkg::*;
#(
  parameter logic [NONCE_W-1:0] NONCE_BASE  = 32'h0000_0000,
  parameter int                 NONCE_COUNT = 4,
  parameter int                 ROUNDS      = ROUNDS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               hit,
  output logic               ready,
  output logic               init_state,
  output logic               round_en,
  output logic [RIDX_W-1:0]  round_idx,
  output logic               final_add,
  output logic               digest_valid,
  output logic [NONCE_W-1:0] nonce,
  output logic               found_all,
  output logic [31:0]        hit_count,
  output logic [NONCE_W-1:0] first_hit_nonce
);

  if (NONCE_COUNT < 1) begin : g_bad_nonce_count
    $error("sha_sweep_ctrl: NONCE_COUNT must be >= 1");
  end
  if (ROUNDS < 1 || ROUNDS > 64) begin : g_bad_rounds
    $error("sha_sweep_ctrl: ROUNDS must be within 1..64");
  end

  localparam logic [RIDX_W-1:0] LAST_RND = RIDX_W'(ROUNDS - 1);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  state_e state, state_d;
  logic   load, advance, last_nonce;

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:  if (start) state_d = ST_INIT;
      ST_INIT:  state_d = abort ? ST_IDLE : ST_ROUND;
      ST_ROUND: begin
        if (abort)                       state_d = ST_IDLE;
        else if (round_idx == LAST_RND)  state_d = ST_FINAL;
      end
      ST_FINAL: state_d = abort ? ST_IDLE : ST_VALID;
      ST_VALID: begin
        if (abort)           state_d = ST_IDLE;
        else if (last_nonce) state_d = ST_DONE;
        else                 state_d = ST_INIT;
      end
      ST_DONE:  if (!start) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign load    = (state == ST_IDLE) && start;
  assign advance = (state == ST_VALID) && (state_d == ST_INIT);

  // Moore outputs are registered from the next state so they change cleanly at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      ready        <= 1'b1;
      init_state   <= 1'b0;
      round_en     <= 1'b0;
      round_idx    <= '0;
      final_add    <= 1'b0;
      digest_valid <= 1'b0;
      found_all    <= 1'b0;
    end else begin
      state        <= state_d;
      ready        <= (state_d == ST_IDLE);
      init_state   <= (state_d == ST_INIT);
      round_en     <= (state_d == ST_ROUND);
      round_idx    <= (state_d == ST_ROUND && state == ST_ROUND) ? round_idx + 1'b1 : '0;
      final_add    <= (state_d == ST_FINAL);
      digest_valid <= (state_d == ST_VALID);
      found_all    <= (state_d == ST_DONE);
    end
  end

  // hit_count never returns to zero once it leaves it, so zero marks "no hit yet".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count       <= '0;
      first_hit_nonce <= '0;
    end else if (load) begin
      hit_count       <= '0;
      first_hit_nonce <= '0;
    end else if (state == ST_VALID && hit) begin
      if (hit_count == 32'd0) first_hit_nonce <= nonce;
      hit_count <= sat_inc(hit_count);
    end
  end

  sha_nonce_counter #(
    .NONCE_BASE  (NONCE_BASE),
    .NONCE_COUNT (NONCE_COUNT)
  ) u_nonce (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .advance    (advance),
    .nonce      (nonce),
    .last_nonce (last_nonce)
  );

endmodule
